// File: rtl/wave_pkg.sv
// wave_pkg: shared widths, config field selects and scheduler state encodings
package wave_pkg;
    localparam int DW = 16;
    localparam int RW = 32;
    localparam logic [1:0] CFG_AMP   = 2'd0;
    localparam logic [1:0] CFG_FREQ  = 2'd1;
    localparam logic [1:0] CFG_PHASE = 2'd2;
    localparam logic [1:0] CFG_EN    = 2'd3;
    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT, FINISH} state_t;
endpackage

// File: rtl/wave_mac.sv
// wave_mac: unsigned amp * (freq * t + phase), every stage truncated to 32 bits
module wave_mac
    import wave_pkg::*;
(
    input  logic [DW-1:0] amp,
    input  logic [DW-1:0] freq,
    input  logic [DW-1:0] phase,
    input  logic [DW-1:0] t,
    output logic [RW-1:0] res
);
    logic [RW-1:0] sum;
    assign sum = RW'(freq) * RW'(t) + RW'(phase);
    assign res = sum * RW'(amp);
endmodule

// File: rtl/wave_scheduler.sv
// wave_scheduler: time-shares one wave_mac across four channels per sample tick
module wave_scheduler
    import wave_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_ch,
    input  logic [1:0]    cfg_sel,
    input  logic [DW-1:0] cfg_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic [1:0]    out_ch,
    output logic [DW-1:0] t_now,
    output logic          busy,
    output logic          overrun,
    input  logic          overrun_clr
);
    state_t state, state_n;
    logic [1:0] idx, idx_n;
    logic [DW-1:0] amp [NCH], freq [NCH], phase [NCH];
    logic [DW-1:0] s_amp [NCH], s_freq [NCH], s_phase [NCH];
    logic [NCH-1:0] en, s_en;
    logic [DW-1:0] t;
    logic [RW-1:0] res;
    logic load, start, last;
    wave_mac u_mac (
        .amp   (s_amp[idx]),
        .freq  (s_freq[idx]),
        .phase (s_phase[idx]),
        .t     (t),
        .res   (res)
    );
    assign last  = idx == 2'(NCH - 1);
    assign start = state == IDLE && tick;
    assign busy  = state != IDLE;
    assign t_now = t;
    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        case (state)
            IDLE: begin
                state_n = tick ? COMPUTE : IDLE;
                idx_n   = tick ? 2'd0 : idx;
            end
            COMPUTE: begin
                load    = s_en[idx];
                state_n = s_en[idx] ? OUTPUT : last ? FINISH : COMPUTE;
                idx_n   = (s_en[idx] || last) ? idx : idx + 2'd1;
            end
            OUTPUT: begin
                state_n = out_ready ? (last ? FINISH : COMPUTE) : OUTPUT;
                idx_n   = (out_ready && !last) ? idx + 2'd1 : idx;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= 2'd0;
            t         <= '0;
            overrun   <= 1'b0;
            amp       <= '{default: '0};
            freq      <= '{default: '0};
            phase     <= '{default: '0};
            en        <= '0;
            s_amp     <= '{default: '0};
            s_freq    <= '{default: '0};
            s_phase   <= '{default: '0};
            s_en      <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (cfg_we && cfg_sel == CFG_AMP)   amp[cfg_ch]   <= cfg_data;
            if (cfg_we && cfg_sel == CFG_FREQ)  freq[cfg_ch]  <= cfg_data;
            if (cfg_we && cfg_sel == CFG_PHASE) phase[cfg_ch] <= cfg_data;
            if (cfg_we && cfg_sel == CFG_EN)    en[cfg_ch]    <= cfg_data[0];
            // snapshot takes pre-edge live values, so a same-edge write waits a round
            if (start) begin
                s_amp   <= amp;
                s_freq  <= freq;
                s_phase <= phase;
                s_en    <= en;
            end
            if (load) begin
                out_data  <= res;
                out_ch    <= idx;
                out_valid <= 1'b1;
            end else if (state == OUTPUT && out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == FINISH) t <= t + 1'b1;
            overrun <= (tick && state != IDLE) | (overrun & ~overrun_clr);
        end
    end
endmodule

// File: tb/tb_wave_scheduler.sv
// tb_wave_scheduler: scoreboard bench for wave_scheduler against a behavioural model
module tb_wave_scheduler;
    import wave_pkg::*;
    logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0, cfg_sel = 2'd0;
    logic [15:0] cfg_data = '0;
    logic out_valid, out_ready = 1'b1, busy, overrun, overrun_clr = 1'b0;
    logic [31:0] out_data;
    logic [1:0] out_ch;
    logic [15:0] t_now;
    int checks = 0, errors = 0, nhs = 0;
    logic [15:0] m_amp [4], m_freq [4], m_phase [4];
    logic [3:0] m_en;
    logic [15:0] mt;
    logic [33:0] sbq [$];
    logic prev_v = 1'b0, prev_r = 1'b0, prev_rn = 1'b0;
    logic [31:0] prev_d = '0;
    logic [1:0] prev_c = '0;
    wave_scheduler dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .t_now(t_now), .busy(busy),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model(input int c, input logic [15:0] tt);
        longint unsigned s;
        s = (longint'(m_freq[c]) * longint'(tt) + longint'(m_phase[c])) & 64'hFFFF_FFFF;
        return 32'((s * longint'(m_amp[c])) & 64'hFFFF_FFFF);
    endfunction
    always @(negedge clk) begin
        if (prev_rn && prev_v && !prev_r) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", out_data, prev_d);
            chk("hold_ch", {30'd0, out_ch}, {30'd0, prev_c});
        end
        if (reset_n && out_valid && out_ready) begin
            nhs++;
            if (sbq.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
                logic [33:0] e;
                e = sbq.pop_front();
                chk("out_ch", {30'd0, out_ch}, {30'd0, e[33:32]});
                chk("out_data", out_data, e[31:0]);
            end
        end
        prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_c = out_ch; prev_rn = reset_n;
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic model_clear();
        m_amp = '{default: '0}; m_freq = '{default: '0}; m_phase = '{default: '0};
        m_en = '0; mt = '0; sbq.delete();
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        step();
        model_clear();
        step();
        reset_n = 1'b1;
    endtask
    task automatic cfg(input int c, input logic [1:0] sel, input logic [15:0] d);
        cfg_we = 1'b1; cfg_ch = 2'(c); cfg_sel = sel; cfg_data = d;
        step();
        cfg_we = 1'b0;
        if (sel == CFG_AMP) m_amp[c] = d;
        if (sel == CFG_FREQ) m_freq[c] = d;
        if (sel == CFG_PHASE) m_phase[c] = d;
        if (sel == CFG_EN) m_en[c] = d[0];
    endtask
    task automatic chan(input int c, input logic [15:0] a, input logic [15:0] f, input logic [15:0] p, input bit e);
        cfg(c, CFG_AMP, a); cfg(c, CFG_FREQ, f); cfg(c, CFG_PHASE, p); cfg(c, CFG_EN, {15'd0, e});
    endtask
    task automatic start();
        for (int c = 0; c < 4; c++) if (m_en[c]) sbq.push_back({2'(c), model(c, mt)});
        mt++;
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 500) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'd0, n < 500}, 32'd1);
    endtask
    initial begin
        int n, h0;
        logic [15:0] t0;
        model_clear();
        step(); step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ch", {30'd0, out_ch}, 32'd0);
        chk("rst_t", {16'd0, t_now}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        step();
        // basic result, first-result latency and t advance
        chan(0, 16'd2, 16'd3, 16'd5, 1'b1);
        start();
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_compute", {31'd0, out_valid}, 32'd0);
        step();
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_value", out_data, 32'd10);
        wait_idle(n);
        start(); wait_idle(n);
        chk("t_after2", {16'd0, t_now}, 32'd2);
        chk("sb_empty1", sbq.size(), 32'd0);
        // truncation on a lone ch1
        do_reset();
        chan(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        start(); wait_idle(n);
        start(); wait_idle(n);
        chk("sb_empty2", sbq.size(), 32'd0);
        // ordering and skip with ch0 and ch2
        do_reset();
        chan(0, 16'd9, 16'd100, 16'd7, 1'b1);
        chan(2, 16'd1234, 16'd4321, 16'hABCD, 1'b1);
        start(); wait_idle(n);
        chk("len_2ch", n + 1, 32'd8);
        start(); wait_idle(n);
        chk("sb_empty3", sbq.size(), 32'd0);
        // four enabled, then backpressure on ch0
        chan(1, 16'd3, 16'd5, 16'd11, 1'b1);
        chan(3, 16'h8001, 16'hF00F, 16'h1234, 1'b1);
        start(); wait_idle(n);
        chk("len_4ch", n + 1, 32'd10);
        out_ready = 1'b0;
        h0 = nhs;
        start();
        step();
        repeat (5) step();
        out_ready = 1'b1;
        wait_idle(n);
        chk("one_xfer_per_ch", nhs - h0, 32'd4);
        chk("sb_empty4", sbq.size(), 32'd0);
        // overrun and shadowing
        t0 = t_now;
        start();
        tick = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = CFG_AMP; cfg_data = 16'd7;
        step();
        tick = 1'b0; cfg_we = 1'b0; m_amp[0] = 16'd7;
        wait_idle(n);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("t_one_round", {16'd0, t_now}, {16'd0, t0 + 16'd1});
        start(); wait_idle(n);
        chk("sb_empty5", sbq.size(), 32'd0);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("overrun_clr", {31'd0, overrun}, 32'd0);
        start();
        tick = 1'b1; overrun_clr = 1'b1; step(); tick = 1'b0; overrun_clr = 1'b0;
        chk("overrun_set_wins", {31'd0, overrun}, 32'd1);
        wait_idle(n);
        // reset while stalled in OUTPUT
        out_ready = 1'b0;
        start();
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("reach_output", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        model_clear();
        out_ready = 1'b1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_t", {16'd0, t_now}, 32'd0);
        chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        start(); wait_idle(n);
        chk("len_0ch", n + 1, 32'd6);
        chk("t_after_rst", {16'd0, t_now}, 32'd1);
        chk("sb_empty6", sbq.size(), 32'd0);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
